lsu_mem_stage: RTL and testbench
================================

Name: lsu_mem_stage

Overview:
- Load/store unit between execute and writeback in the riscv64i core.
- Accepts one memory op per transaction from execute (effective address already computed) and drives a single-outstanding data-memory port.
- Shifts store data into byte lanes with matching byte strobes.
- Aligns load data, then sign-/zero-extends it (LB/LH/LW/LD/LBU/LHU/LWU) before handing the result to writeback.

Parameters:
- DATA_WIDTH, 64, data and address width; the only supported value is 64.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  execute has an op
- req_ready  out  1  unit can accept an op
- req_is_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RV64I load/store funct3
- req_addr  in  64  effective byte address
- req_wdata  in  64  store data, right-justified
- req_rd  in  5  load destination register
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_we  out  1  write enable
- mem_req_addr  out  64  8-byte-aligned address (req_addr with bits [2:0] cleared)
- mem_req_wdata  out  64  lane-shifted store data
- mem_req_wstrb  out  8  byte strobes, 0 for loads
- mem_resp_valid  in  1  read data or write ack, one-cycle pulse
- mem_resp_rdata  in  64  read doubleword
- resp_valid  out  1  result for writeback
- resp_ready  in  1  writeback accepts
- resp_data  out  64  extended load result, 0 for stores and faults
- resp_rd  out  5  captured req_rd
- resp_fault  out  1  misaligned or illegal funct3

Behaviour:
- FSM states: IDLE, MREQ, MWAIT, RESP. All request/response fields are registered.
- Reset (asynchronous, any state): state goes to IDLE.
  - All outputs are 0, except req_ready, which is 1.
  - Ports driven 0: mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb, resp_valid, resp_data, resp_rd, resp_fault.
- req_ready is 1 only in IDLE. Accept occurs on req_valid && req_ready.
- Size from funct3[1:0]: 00 = 1 byte, 01 = 2, 10 = 4, 11 = 8.
- Legal funct3:
  - Loads: 000–110; 111 is illegal.
  - Stores: 000–011; 1xx is illegal.
- Misaligned: byte offset addr[2:0] is not a multiple of the size.
- Accept, illegal or misaligned op: go to RESP with resp_fault=1 and resp_data=0. mem_req_valid never asserts.
- Accept, legal and aligned op: go to MREQ.
  - mem_req_addr = {addr[63:3], 3'b0}.
  - Store: mem_req_wdata = req_wdata << (8*off); mem_req_wstrb = size mask (0x01/0x03/0x0F/0xFF) << off.
  - Load: mem_req_wdata = 0; mem_req_wstrb = 0.
- MREQ:
  - mem_req_valid=1. All mem_req_* fields stay stable until mem_req_ready.
  - On mem_req_valid && mem_req_ready: go to MWAIT and drop mem_req_valid.
- MWAIT:
  - Waits indefinitely for mem_resp_valid.
  - Load: take rdata >> (8*off), then extend by funct3. 000 sext8, 001 sext16, 010 sext32, 011 passthrough, 100 zext8, 101 zext16, 110 zext32.
  - Store: resp_data=0 (mem_resp_valid is only an ack).
  - Then go to RESP.
- mem_resp_valid in any state other than MWAIT is ignored, including a response in the same cycle as the request handshake.
- RESP:
  - resp_valid=1. resp_* fields stay stable until resp_ready.
  - On handshake: go to IDLE. A new op can be accepted no earlier than the following cycle.
- Latency with a zero-wait memory: accept at edge T → mem_req_valid in cycle T+1 → MWAIT at T+2 → if mem_resp_valid in T+2, resp_valid in T+3.
- Fault latency: resp_valid one cycle after accept.
- Reset mid-transaction: the op is abandoned; a later mem_resp_valid is ignored.

Test Plan:
- LB at 0x1003, mem_resp_rdata 0x1122334480556677 → mem_req_addr 0x1000, wstrb 0x00; resp_data 0xFFFFFFFFFFFFFF80. The same with LBU gives 0x0000000000000080.
- SH at 0x2006, req_wdata 0x...ABCD → mem_req_we=1, mem_req_addr 0x2000, wstrb 0xC0, wdata 0xABCD000000000000. After ack: resp_data 0, resp_fault 0.
- LW at 0x1002 → mem_req_valid stays 0; resp_valid one cycle after accept with resp_fault=1, resp_data 0. Store funct3=100 gives the same response.
- LD at 0x3008 with mem_req_ready low for 3 cycles → mem_req_valid and address held for 4 cycles. LWU with rdata upper word 0xDEADBEEF at offset 4 → resp_data 0x00000000DEADBEEF.
- resp_ready low for 5 cycles → resp_valid/resp_data/resp_rd stable; req_ready=0 throughout; a spurious mem_resp_valid has no effect.
- rst asserted while in MWAIT → all outputs 0 at once, req_ray_ready=1. A mem_resp_valid after reset produces no resp_valid; the next LD completes normally.

Source files
------------

// File: rtl/lsu_mem_stage.sv
// Load/store unit between execute and writeback: one op in flight, lane-shifted
// stores with byte strobes, aligned and sign/zero-extended loads.
module lsu_mem_stage #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_is_store,
    input  logic [2:0]            req_funct3,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [4:0]            req_rd,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_we,
    output logic [DATA_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    output logic [7:0]            mem_req_wstrb,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_rdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic [4:0]            resp_rd,
    output logic                  resp_fault
);

    typedef enum logic [1:0] {IDLE, MREQ, MWAIT, RESP} state_t;

    state_t                state_q, state_d;
    logic [2:0]            off_q, off_d;
    logic [2:0]            funct3_q, funct3_d;
    logic                  is_store_q, is_store_d;
    logic                  mem_we_q, mem_we_d;
    logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [7:0]            mem_wstrb_q, mem_wstrb_d;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
    logic [4:0]            resp_rd_q, resp_rd_d;
    logic                  resp_fault_q, resp_fault_d;

    logic [7:0]            size_mask;
    logic                  misaligned;
    logic                  illegal;
    logic [DATA_WIDTH-1:0] load_shifted;
    logic [DATA_WIDTH-1:0] load_ext;

    always_comb begin
        size_mask  = 8'h01;
        misaligned = 1'b0;
        case (req_funct3[1:0])
            2'b00: begin size_mask = 8'h01; misaligned = 1'b0;            end
            2'b01: begin size_mask = 8'h03; misaligned = req_addr[0];     end
            2'b10: begin size_mask = 8'h0F; misaligned = |req_addr[1:0];  end
            default: begin size_mask = 8'hFF; misaligned = |req_addr[2:0]; end
        endcase
        illegal = req_is_store ? req_funct3[2] : (req_funct3 == 3'b111);
    end

    // Loaded doubleword is brought down to bit 0 before extension.
    always_comb begin
        load_shifted = mem_resp_rdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  load_ext = {{56{load_shifted[7]}},  load_shifted[7:0]};
            3'b001:  load_ext = {{48{load_shifted[15]}}, load_shifted[15:0]};
            3'b010:  load_ext = {{32{load_shifted[31]}}, load_shifted[31:0]};
            3'b100:  load_ext = {56'd0, load_shifted[7:0]};
            3'b101:  load_ext = {48'd0, load_shifted[15:0]};
            3'b110:  load_ext = {32'd0, load_shifted[31:0]};
            default: load_ext = load_shifted;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        off_d        = off_q;
        funct3_d     = funct3_q;
        is_store_d   = is_store_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        resp_data_d  = resp_data_q;
        resp_rd_d    = resp_rd_q;
        resp_fault_d = resp_fault_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    off_d       = req_addr[2:0];
                    funct3_d    = req_funct3;
                    is_store_d  = req_is_store;
                    resp_rd_d   = req_rd;
                    resp_data_d = '0;
                    if (illegal || misaligned) begin
                        resp_fault_d = 1'b1;
                        mem_we_d     = 1'b0;
                        mem_addr_d   = '0;
                        mem_wdata_d  = '0;
                        mem_wstrb_d  = '0;
                        state_d      = RESP;
                    end else begin
                        resp_fault_d = 1'b0;
                        mem_we_d     = req_is_store;
                        mem_addr_d   = {req_addr[DATA_WIDTH-1:3], 3'b000};
                        mem_wdata_d  = req_is_store ? (req_wdata << {req_addr[2:0], 3'b000}) : '0;
                        mem_wstrb_d  = req_is_store ? (size_mask << req_addr[2:0]) : 8'h00;
                        state_d      = MREQ;
                    end
                end
            end
            MREQ: begin
                if (mem_req_ready) state_d = MWAIT;
            end
            MWAIT: begin
                if (mem_resp_valid) begin
                    resp_data_d = is_store_q ? '0 : load_ext;
                    state_d     = RESP;
                end
            end
            default: begin
                if (resp_ready) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            off_q        <= '0;
            funct3_q     <= '0;
            is_store_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
            resp_data_q  <= '0;
            resp_rd_q    <= '0;
            resp_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            off_q        <= off_d;
            funct3_q     <= funct3_d;
            is_store_q   <= is_store_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
            resp_data_q  <= resp_data_d;
            resp_rd_q    <= resp_rd_d;
            resp_fault_q <= resp_fault_d;
        end
    end

    assign req_ready     = (state_q == IDLE);
    assign mem_req_valid = (state_q == MREQ);
    assign mem_req_we    = mem_we_q;
    assign mem_req_addr  = mem_addr_q;
    assign mem_req_wdata = mem_wdata_q;
    assign mem_req_wstrb = mem_wstrb_q;
    assign resp_valid    = (state_q == RESP);
    assign resp_data     = resp_data_q;
    assign resp_rd       = resp_rd_q;
    assign resp_fault    = resp_fault_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: loads, stores, faults, backpressure and reset.
module tb_lsu_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_is_store;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req_valid, mem_req_ready, mem_req_we;
    logic [63:0] mem_req_addr, mem_req_wdata;
    logic [7:0]  mem_req_wstrb;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_rdata;
    logic        resp_valid, resp_ready;
    logic [63:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_mem_stage #(.DATA_WIDTH(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_rd(resp_rd), .resp_fault(resp_fault)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic st, input logic [2:0] f3, input logic [63:0] a,
                          input logic [63:0] wd, input logic [4:0] rd);
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
        req_addr = a; req_wdata = wd; req_rd = rd;
        tick();
        req_valid = 1'b0;
    endtask

    // From MREQ with zero-wait memory: handshake, then one response pulse.
    task automatic mem_roundtrip(input logic [63:0] rdata);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_rdata = rdata;
        tick();
        mem_resp_valid = 1'b0;
    endtask

    task automatic finish_resp;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if ({req_ready, mem_req_valid, mem_req_we, mem_req_wstrb, resp_valid, resp_rd, resp_fault} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0}) begin
            errors++; $display("FAIL reset_ctrl got %b", {req_ready, mem_req_valid, mem_req_we, mem_req_wstrb, resp_valid, resp_rd, resp_fault});
        end
        checks++;
        if ({mem_req_addr, mem_req_wdata, resp_data} !== 192'd0) begin
            errors++; $display("FAIL reset_data addr %h wdata %h data %h want 0", mem_req_addr, mem_req_wdata, resp_data);
        end
        $display("reset: req_ready=%b", req_ready);
    endtask

    task automatic test_load_byte(input logic [2:0] f3, input logic [63:0] exp);
        accept(1'b0, f3, 64'h1003, 64'd0, 5'd7);
        checks++;
        if ({mem_req_valid, mem_req_we, mem_req_wstrb, mem_req_addr, mem_req_wdata} !== {1'b1, 1'b0, 8'h00, 64'h1000, 64'd0}) begin
            errors++; $display("FAIL lb_req v %b we %b strb %h addr %h want 1 0 00 1000", mem_req_valid, mem_req_we, mem_req_wstrb, mem_req_addr);
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        checks++;
        if (mem_req_valid !== 1'b0) begin
            errors++; $display("FAIL lb_drop mem_req_valid %b want 0", mem_req_valid);
        end
        mem_resp_valid = 1'b1; mem_resp_rdata = 64'h1122334480556677;
        tick();
        mem_resp_valid = 1'b0;
        checks++;
        if ({resp_valid, resp_fault, resp_rd, resp_data} !== {1'b1, 1'b0, 5'd7, exp}) begin
            errors++; $display("FAIL load_byte f3 %0d got v %b f %b rd %0d data %h want data %h", f3, resp_valid, resp_fault, resp_rd, resp_data, exp);
        end
        $display("load f3=%0d addr 1003 -> %h", f3, resp_data);
        finish_resp();
        checks++;
        if ({req_ready, resp_valid} !== 2'b10) begin
            errors++; $display("FAIL lb_idle ready %b resp_valid %b want 1 0", req_ready, resp_valid);
        end
    endtask

    task automatic test_store_half;
        accept(1'b1, 3'b001, 64'h2006, 64'h123456789ABCABCD, 5'd0);
        checks++;
        if ({mem_req_valid, mem_req_we, mem_req_wstrb, mem_req_addr, mem_req_wdata} !== {1'b1, 1'b1, 8'hC0, 64'h2000, 64'hABCD000000000000}) begin
            errors++; $display("FAIL sh_req we %b strb %h addr %h wdata %h want 1 c0 2000 abcd000000000000", mem_req_we, mem_req_wstrb, mem_req_addr, mem_req_wdata);
        end
        mem_roundtrip(64'hFFFFFFFFFFFFFFFF);
        checks++;
        if ({resp_valid, resp_fault, resp_data} !== {1'b1, 1'b0, 64'd0}) begin
            errors++; $display("FAIL sh_resp v %b f %b data %h want 1 0 0", resp_valid, resp_fault, resp_data);
        end
        $display("store SH addr 2006 strb %h", mem_req_wstrb);
        finish_resp();
    endtask

    task automatic test_fault(input logic st, input logic [2:0] f3, input logic [63:0] a);
        accept(st, f3, a, 64'h55, 5'd9);
        checks++;
        if ({mem_req_valid, resp_valid, resp_fault, resp_rd, resp_data} !== {1'b0, 1'b1, 1'b1, 5'd9, 64'd0}) begin
            errors++; $display("FAIL fault st %b f3 %0d mv %b rv %b f %b data %h want 0 1 1 0", st, f3, mem_req_valid, resp_valid, resp_fault, resp_data);
        end
        $display("fault st=%b f3=%0d addr %h -> fault %b", st, f3, a, resp_fault);
        finish_resp();
    endtask

    task automatic test_ld_stall;
        accept(1'b0, 3'b011, 64'h3008, 64'd0, 5'd3);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_req_ready = 1'b1;
            checks++;
            if ({mem_req_valid, mem_req_addr} !== {1'b1, 64'h3008}) begin
                errors++; $display("FAIL ld_hold cycle %0d v %b addr %h want 1 3008", i, mem_req_valid, mem_req_addr);
            end
            tick();
        end
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_rdata = 64'h0123456789ABCDEF;
        tick();
        mem_resp_valid = 1'b0;
        checks++;
        if ({resp_valid, resp_data} !== {1'b1, 64'h0123456789ABCDEF}) begin
            errors++; $display("FAIL ld_data v %b data %h want 1 0123456789abcdef", resp_valid, resp_data);
        end
        $display("LD addr 3008 stalled -> %h", resp_data);
        finish_resp();
    endtask

    task automatic test_word(input logic [2:0] f3, input logic [63:0] exp);
        accept(1'b0, f3, 64'h3004, 64'd0, 5'd4);
        mem_roundtrip(64'hDEADBEEF00000000);
        checks++;
        if ({resp_valid, resp_data} !== {1'b1, exp}) begin
            errors++; $display("FAIL word f3 %0d data %h want %h", f3, resp_data, exp);
        end
        $display("word f3=%0d addr 3004 -> %h", f3, resp_data);
        finish_resp();
    endtask

    task automatic test_resp_hold;
        accept(1'b0, 3'b001, 64'h4002, 64'd0, 5'd21);
        mem_roundtrip(64'h0000000080010000);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin mem_resp_valid = 1'b1; mem_resp_rdata = 64'h7777777777777777; end
            checks++;
            if ({resp_valid, req_ready, resp_rd, resp_data} !== {1'b1, 1'b0, 5'd21, 64'hFFFFFFFFFFFF8001}) begin
                errors++; $display("FAIL resp_hold cycle %0d v %b rdy %b rd %0d data %h want 1 0 21 ffffffffffff8001", i, resp_valid, req_ready, resp_rd, resp_data);
            end
            tick();
            mem_resp_valid = 1'b0;
        end
        $display("LH addr 4002 held 5 cycles -> %h", resp_data);
        finish_resp();
    endtask

    task automatic test_reset_mwait;
        accept(1'b0, 3'b011, 64'h5000, 64'd0, 5'd12);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({req_ready, mem_req_valid, mem_req_we, mem_req_wstrb, resp_valid, resp_rd, resp_fault, mem_req_addr, resp_data} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 64'd0, 64'd0}) begin
            errors++; $display("FAIL rst_mwait rdy %b mv %b addr %h rv %b rd %0d want 1 0 0 0 0", req_ready, mem_req_valid, mem_req_addr, resp_valid, resp_rd);
        end
        #1;
        rst = 1'b0;
        tick();
        mem_resp_valid = 1'b1; mem_resp_rdata = 64'h1111111111111111;
        tick();
        mem_resp_valid = 1'b0;
        checks++;
        if ({resp_valid, req_ready} !== 2'b01) begin
            errors++; $display("FAIL rst_stale resp_valid %b req_ready %b want 0 1", resp_valid, req_ready);
        end
        accept(1'b0, 3'b011, 64'h5000, 64'd0, 5'd13);
        mem_roundtrip(64'hCAFEF00D12345678);
        checks++;
        if ({resp_valid, resp_rd, resp_data} !== {1'b1, 5'd13, 64'hCAFEF00D12345678}) begin
            errors++; $display("FAIL rst_after_ld v %b rd %0d data %h want 1 13 cafef00d12345678", resp_valid, resp_rd, resp_data);
        end
        $display("reset in MWAIT, next LD -> %h", resp_data);
        finish_resp();
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b0;
        req_addr = '0; req_wdata = '0; req_rd = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
        resp_ready = 1'b0;
        #3;
        test_reset();
        tick();
        rst = 1'b0;
        tick();
        test_load_byte(3'b000, 64'hFFFFFFFFFFFFFF80);
        test_load_byte(3'b100, 64'h0000000000000080);
        test_store_half();
        test_fault(1'b0, 3'b010, 64'h1002);
        test_fault(1'b1, 3'b100, 64'h1000);
        test_fault(1'b0, 3'b111, 64'h1000);
        test_ld_stall();
        test_word(3'b110, 64'h00000000DEADBEEF);
        test_word(3'b010, 64'hFFFFFFFFDEADBEEF);
        test_resp_hold();
        test_reset_mwait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
